// File: rtl/lap_stopwatch.sv
// Lap stopwatch: debounced start/stop, clear and lap buttons, BCD MM:SS:CC
// counter that counts up or down from a preset, and a small lap register file.

// Per-button front end: 2-flop synchroniser, stability-window debouncer and
// a one-cycle press pulse on each debounced release->press transition.
module buttonDebounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic rawButton,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync1, sync2, level, levelDly;
    logic [CW-1:0] stableCnt;

    // Level follows the synchronised input only after DB_CYCLES differing cycles in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            level     <= 1'b1;
            levelDly  <= 1'b1;
            stableCnt <= '0;
        end else begin
            sync1    <= rawButton;
            sync2    <= sync1;
            levelDly <= level;
            if (sync2 == level) begin
                stableCnt <= '0;
            end else if (stableCnt == CW'(DB_CYCLES - 1)) begin
                level     <= sync2;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + CW'(1);
            end
        end
    end

    // High exactly for the cycle right after the debounced level has fallen.
    assign press = levelDly & ~level;
endmodule

module lap_stopwatch #(
    parameter  int CLK_HZ    = 50000000,
    parameter  int TICK_HZ   = 100,
    parameter  int FAST_MULT = 10,
    parameter  int DB_CYCLES = 500000,
    parameter  int LAP_DEPTH = 4,
    localparam int SEL_W     = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    localparam int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             startStopButton,
    input  logic             clearButton,
    input  logic             lapButton,
    input  logic             speed,
    input  logic             countDown,
    input  logic [23:0]      presetBcd,
    input  logic [SEL_W-1:0] lapSel,
    output logic [23:0]      timeBcd,
    output logic             running,
    output logic             expired,
    output logic [23:0]      lapBcd,
    output logic [CNT_W-1:0] lapCount
);
    localparam int          NBTN     = 3;
    localparam int          SLOW_PER = CLK_HZ / TICK_HZ;
    localparam int          FAST_PER = CLK_HZ / (TICK_HZ * FAST_MULT);
    localparam int          TW       = (SLOW_PER > 1) ? $clog2(SLOW_PER) : 1;
    localparam logic [23:0] TIME_MAX = 24'h995999;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} stateT;

    stateT                        state, nextState;
    logic [NBTN-1:0]              rawBtn, pressVec;
    logic                         startPress, clearPress, lapPress;
    logic [TW-1:0]                tickCnt, tickLim, newLim;
    logic                         tick;
    logic                         modeDown;
    logic [23:0]                  timeReg, timeNext, presetLoad;
    logic                         atLimit, timeEnd, lapTake;
    logic [LAP_DEPTH-1:0][23:0]   laps;

    // Largest legal value of each BCD digit; only the seconds-tens digit stops at 5.
    function automatic logic [3:0] digitMax(input int i);
        return (i == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [23:0] clampBcd(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        for (int i = 0; i < 6; i++)
            if (t[i*4 +: 4] > digitMax(i)) r[i*4 +: 4] = digitMax(i);
        return r;
    endfunction

    // One centisecond step with carry (up) or borrow (down) rippling through all digits.
    function automatic logic [23:0] stepBcd(input logic [23:0] t, input logic down);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  d;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = t[i*4 +: 4];
            if (carry) begin
                if (down) begin
                    if (d == 4'd0) r[i*4 +: 4] = digitMax(i);
                    else begin r[i*4 +: 4] = d - 4'd1; carry = 1'b0; end
                end else begin
                    if (d >= digitMax(i)) r[i*4 +: 4] = 4'd0;
                    else begin r[i*4 +: 4] = d + 4'd1; carry = 1'b0; end
                end
            end
        end
        return r;
    endfunction

    assign rawBtn = {lapButton, clearButton, startStopButton};

    genvar b;
    generate
        for (b = 0; b < NBTN; b++) begin : gBtn
            buttonDebounce #(.DB_CYCLES(DB_CYCLES)) uDb (
                .clock     (clock),
                .reset     (reset),
                .rawButton (rawBtn[b]),
                .press     (pressVec[b])
            );
        end
    endgenerate

    assign startPress = pressVec[0];
    assign clearPress = pressVec[1];
    assign lapPress   = pressVec[2];

    // Tick period: the limit is only re-sampled from speed when a period restarts.
    assign newLim = speed ? TW'(FAST_PER - 1) : TW'(SLOW_PER - 1);
    assign tick   = (state == RUN) && (tickCnt == tickLim);

    // Tick counter runs in RUN, holds in PAUSE, and sits at zero otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            tickCnt <= '0;
            tickLim <= TW'(SLOW_PER - 1);
        end else if (state == RUN) begin
            if (tick) begin
                tickCnt <= '0;
                tickLim <= newLim;
            end else begin
                tickCnt <= tickCnt + TW'(1);
            end
        end else if (state != PAUSE) begin
            tickCnt <= '0;
            tickLim <= newLim;
        end
    end

    // Count direction tracks countDown while idle and is frozen otherwise.
    always_ff @(posedge clock) begin
        if (reset)              modeDown <= 1'b0;
        else if (state == IDLE) modeDown <= countDown;
    end

    assign presetLoad = countDown ? clampBcd(presetBcd) : 24'h0;
    assign timeNext   = stepBcd(timeReg, modeDown);
    assign atLimit    = modeDown ? (timeReg == 24'h0) : (timeReg == TIME_MAX);
    assign timeEnd    = modeDown ? (timeReg <= 24'h000001) : atLimit;

    // Time register: reloaded while idle or on clear, stepped on ticks, pinned at the end value.
    always_ff @(posedge clock) begin
        if (reset)                                 timeReg <= 24'h0;
        else if (clearPress || state == IDLE)      timeReg <= presetLoad;
        else if (tick && !atLimit)                 timeReg <= timeNext;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next state and status outputs; clear overrides every other event.
    always_comb begin
        nextState = state;
        running   = 1'b0;
        expired   = 1'b0;
        unique case (state)
            IDLE:    if (startPress)
                         nextState = (countDown && clampBcd(presetBcd) == 24'h0) ? DONE : RUN;
            RUN: begin
                running = 1'b1;
                if (startPress)           nextState = PAUSE;
                else if (tick && timeEnd) nextState = DONE;
            end
            PAUSE:   if (startPress) nextState = RUN;
            default: expired = 1'b1;
        endcase
        if (clearPress) nextState = IDLE;
    end

    assign lapTake = lapPress && !clearPress && !startPress &&
                     (state == RUN || state == PAUSE) && (lapCount < CNT_W'(LAP_DEPTH));

    // Lap file: append the pre-tick time to the next free slot; clear empties it.
    always_ff @(posedge clock) begin
        if (reset || clearPress) begin
            laps     <= '0;
            lapCount <= '0;
        end else if (lapTake) begin
            for (int i = 0; i < LAP_DEPTH; i++)
                if (CNT_W'(i) == lapCount) laps[i] <= timeReg;
            lapCount <= lapCount + CNT_W'(1);
        end
    end

    // Lap read port returns zero for slots that hold no lap yet.
    always_comb begin
        lapBcd = 24'h0;
        for (int i = 0; i < LAP_DEPTH; i++)
            if (SEL_W'(i) == lapSel && CNT_W'(i) < lapCount) lapBcd = laps[i];
    end

    assign timeBcd = timeReg;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch with a 10-cycle centisecond and 4-cycle debounce.
module tb_lap_stopwatch;
    logic        clock = 1'b0;
    logic        reset;
    logic        startStopButton, clearButton, lapButton;
    logic        speed, countDown;
    logic [23:0] presetBcd;
    logic [0:0]  lapSel;
    logic [23:0] timeBcd, lapBcd;
    logic        running, expired;
    logic [1:0]  lapCount;

    int          passes = 0;
    int          total = 0;
    int          runCycles = 0;
    logic [23:0] expT, lap1Exp, lap2Exp;

    lap_stopwatch #(
        .CLK_HZ(1000), .TICK_HZ(100), .FAST_MULT(10), .DB_CYCLES(4), .LAP_DEPTH(2)
    ) dut (
        .clock(clock), .reset(reset), .startStopButton(startStopButton),
        .clearButton(clearButton), .lapButton(lapButton), .speed(speed),
        .countDown(countDown), .presetBcd(presetBcd), .lapSel(lapSel),
        .timeBcd(timeBcd), .running(running), .expired(expired),
        .lapBcd(lapBcd), .lapCount(lapCount)
    );

    always #5 clock = ~clock;

    // Advance n clocks, counting every cycle spent in RUN.
    task automatic cyc(input int n);
        repeat (n) begin
            if (running) runCycles++;
            @(negedge clock);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Centiseconds to BCD MM:SS:CC.
    function automatic logic [23:0] toBcd(input int cs);
        int cc, ss, mm;
        cc = cs % 100;
        ss = (cs / 100) % 60;
        mm = cs / 6000;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic pressClear();
        clearButton = 1'b0; cyc(8); clearButton = 1'b1; cyc(8);
    endtask

    task automatic pressLap();
        lapButton = 1'b0; cyc(8); lapButton = 1'b1; cyc(10);
    endtask

    initial begin
        reset = 1'b1; startStopButton = 1'b1; clearButton = 1'b1; lapButton = 1'b1;
        speed = 1'b0; countDown = 1'b0; presetBcd = 24'h0; lapSel = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("rst_time", timeBcd, 24'h0);
        chk("rst_running", running, 0);
        chk("rst_expired", expired, 0);
        chk("rst_lapCount", lapCount, 0);
        chk("rst_lapBcd", lapBcd, 24'h0);

        // 3-cycle glitch is shorter than the debounce window
        startStopButton = 1'b0; cyc(3); startStopButton = 1'b1; cyc(12);
        chk("glitch_idle_running", running, 0);
        chk("glitch_idle_time", timeBcd, 24'h0);

        // held start press, then 100 running cycles = 10 ticks
        runCycles = 0;
        startStopButton = 1'b0; cyc(20); startStopButton = 1'b1;
        chk("start_running", running, 1);
        for (int i = 0; i < 300 && runCycles < 100; i++) cyc(1);
        chk("run100_time", timeBcd, 24'h000010);

        startStopButton = 1'b0; cyc(3); startStopButton = 1'b1; cyc(12);
        chk("glitch_run_running", running, 1);
        chk("glitch_run_time", timeBcd, toBcd(runCycles / 10));

        // pause mid-period, idle a while, resume
        startStopButton = 1'b0;
        for (int i = 0; i < 30 && running; i++) cyc(1);
        startStopButton = 1'b1;
        chk("pause_running", running, 0);
        expT = toBcd(runCycles / 10);
        chk("pause_time", timeBcd, expT);
        cyc(30);
        chk("pause_hold", timeBcd, expT);
        startStopButton = 1'b0;
        for (int i = 0; i < 30 && !running; i++) cyc(1);
        cyc(10);
        startStopButton = 1'b1;
        for (int i = 0; i < 300 && runCycles < 200; i++) cyc(1);
        chk("resume_time", timeBcd, 24'h000020);

        // laps taken just after a tick so the captured value is stable
        for (int i = 0; i < 20 && (runCycles % 10) != 1; i++) cyc(1);
        lap1Exp = toBcd(runCycles / 10);
        pressLap();
        chk("lap1_count", lapCount, 1);
        lapSel = 1'b1; #1;
        chk("lap_sel_empty", lapBcd, 24'h0);
        lapSel = 1'b0; #1;
        chk("lap1_value", lapBcd, lap1Exp);
        for (int i = 0; i < 20 && (runCycles % 10) != 1; i++) cyc(1);
        lap2Exp = toBcd(runCycles / 10);
        pressLap();
        for (int i = 0; i < 20 && (runCycles % 10) != 1; i++) cyc(1);
        pressLap();
        chk("lap_full_count", lapCount, 2);
        lapSel = 1'b0; #1;
        chk("lap_slot0", lapBcd, lap1Exp);
        lapSel = 1'b1; #1;
        chk("lap_slot1", lapBcd, lap2Exp);

        // clear and start in the same cycle
        startStopButton = 1'b0; clearButton = 1'b0; cyc(8);
        startStopButton = 1'b1; clearButton = 1'b1; cyc(10);
        chk("clrstart_running", running, 0);
        chk("clrstart_lapCount", lapCount, 0);
        chk("clrstart_time", timeBcd, 24'h0);
        chk("clrstart_lapBcd", lapBcd, 24'h0);

        // fast mode: minute carry
        speed = 1'b1; cyc(2);
        startStopButton = 1'b0; cyc(8); startStopButton = 1'b1; cyc(8);
        startStopButton = 1'b0;
        for (int i = 0; i < 30 && running; i++) cyc(1);
        startStopButton = 1'b1; cyc(8);
        chk("fast_pause_running", running, 0);
        force dut.timeReg = 24'h005995;
        cyc(2);
        release dut.timeReg;
        cyc(1);
        chk("fast_preload", timeBcd, 24'h005995);
        runCycles = 0;
        startStopButton = 1'b0;
        for (int i = 0; i < 30 && !running; i++) cyc(1);
        cyc(10);
        chk("fast_carry", timeBcd, 24'h010005);
        startStopButton = 1'b1; cyc(8);

        // fast mode: saturate at 99:59:99
        startStopButton = 1'b0;
        for (int i = 0; i < 30 && running; i++) cyc(1);
        startStopButton = 1'b1; cyc(8);
        force dut.timeReg = 24'h995998;
        cyc(2);
        release dut.timeReg;
        cyc(1);
        chk("max_preload", timeBcd, 24'h995998);
        startStopButton = 1'b0;
        for (int i = 0; i < 40 && !expired; i++) cyc(1);
        startStopButton = 1'b1; cyc(8);
        chk("max_expired", expired, 1);
        chk("max_time", timeBcd, 24'h995999);
        chk("max_running", running, 0);
        startStopButton = 1'b0; cyc(8); startStopButton = 1'b1; cyc(8);
        chk("done_start_expired", expired, 1);
        chk("done_start_time", timeBcd, 24'h995999);

        // count-down: clamped preset, 3 ticks to zero
        pressClear();
        speed = 1'b0; countDown = 1'b1; presetBcd = 24'h0000A3; cyc(3);
        chk("down_idle_expired", expired, 0);
        chk("down_clamp", timeBcd, 24'h000093);
        presetBcd = 24'h000003; cyc(2);
        chk("down_preset", timeBcd, 24'h000003);
        runCycles = 0;
        startStopButton = 1'b0;
        for (int i = 0; i < 60 && !expired; i++) cyc(1);
        startStopButton = 1'b1;
        chk("down_expired", expired, 1);
        chk("down_time", timeBcd, 24'h0);
        chk("down_cycles", runCycles, 30);

        // count-down from zero goes straight to DONE
        pressClear();
        presetBcd = 24'h0; cyc(2);
        runCycles = 0;
        startStopButton = 1'b0;
        for (int i = 0; i < 30 && !expired; i++) cyc(1);
        startStopButton = 1'b1;
        chk("zero_expired", expired, 1);
        chk("zero_no_run", runCycles, 0);

        // reset in the middle of a run with a press in flight
        cyc(8);
        pressClear();
        countDown = 1'b0; lapSel = 1'b0; cyc(2);
        startStopButton = 1'b0;
        for (int i = 0; i < 30 && !running; i++) cyc(1);
        startStopButton = 1'b1; cyc(30);
        pressLap();
        chk("pre_reset_lapCount", lapCount, 1);
        startStopButton = 1'b0; cyc(3);
        reset = 1'b1; cyc(1);
        chk("mid_rst_time", timeBcd, 24'h0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_expired", expired, 0);
        chk("mid_rst_lapCount", lapCount, 0);
        chk("mid_rst_lapBcd", lapBcd, 24'h0);
        reset = 1'b0; startStopButton = 1'b1; cyc(12);
        chk("post_rst_idle", running, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
